lockin_sweep_scheduler: RTL

LOCKIN_SWEEP_SCHEDULER -- requirements
Module: lockin_sweep_scheduler

---
 rtl/lockin_sweep_pkg.sv | 18 +
 rtl/sweep_averager.sv | 46 ++++
 rtl/lockin_sweep_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lockin_sweep_pkg.sv
// Shared types and default sizes for the lock-in frequency sweep scheduler.
package lockin_sweep_pkg;

    localparam int DEF_FREQ_W   = 13;
    localparam int DEF_MAG_W    = 42;
    localparam int DEF_AVG_LOG2 = 2;

    // Sweep controller states; the encoding is also exported on the debug port.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_SETTLE  = 3'd2,
        S_ACQUIRE = 3'd3,
        S_STORE   = 3'd4,
        S_DONE    = 3'd5
    } sweep_state_t;

endpackage

// File: rtl/sweep_averager.sv
// Accumulates a fixed block of 2^AVG_LOG2 magnitudes for one frequency point.
// The sum is wide enough that a full block of maximum magnitudes cannot overflow.
// Once the block is full, further strobes are ignored until the next clear.
module sweep_averager
    import lockin_sweep_pkg::*;
#(
    parameter int MAG_W    = DEF_MAG_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_clear,
    input  logic                      i_strobe,
    input  logic [MAG_W-1:0]          i_mag,
    output logic [MAG_W+AVG_LOG2-1:0] o_sum,
    output logic                      o_done
);

    localparam int SUM_W = MAG_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] AVG_N = CNT_W'(2 ** AVG_LOG2);

    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             w_take;

    assign w_take = i_strobe && (r_cnt != AVG_N);

    // Sum and count accepted samples; clear restarts the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_sum <= r_sum + SUM_W'(i_mag);
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_sum  = r_sum;
    assign o_done = (r_cnt == AVG_N);

endmodule

// File: rtl/lockin_sweep_scheduler.sv
// Steps a lock-in tuning word from start to stop, discards settling results,
// averages a block of CORDIC magnitudes per point and tracks the sweep peak.
// i_result_valid is a one-cycle strobe with no back-pressure: a sample is
// transferred on every clock edge where it is high, and strobes arriving in
// a state that does not consume them are simply dropped.
module lockin_sweep_scheduler
    import lockin_sweep_pkg::*;
#(
    parameter int FREQ_W   = DEF_FREQ_W,
    parameter int MAG_W    = DEF_MAG_W,
    parameter int SETTLE_N = 2,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [FREQ_W-1:0] i_f_start,
    input  logic [FREQ_W-1:0] i_f_stop,
    input  logic [FREQ_W-1:0] i_f_step,
    input  logic              i_result_valid,
    input  logic [MAG_W-1:0]  i_magnitude,
    output logic [FREQ_W-1:0] o_tuning_word,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cfg_err,
    output logic              o_point_valid,
    output logic [FREQ_W-1:0] o_point_freq,
    output logic [MAG_W-1:0]  o_point_mag,
    output logic [FREQ_W-1:0] o_peak_freq,
    output logic [MAG_W-1:0]  o_peak_mag,
    output sweep_state_t      o_dbg_state
);

    localparam int SUM_W = MAG_W + AVG_LOG2;
    localparam logic [3:0] SETTLE_LAST = (SETTLE_N == 0) ? 4'd0 : 4'(SETTLE_N - 1);

    sweep_state_t       r_state;
    sweep_state_t       w_next_state;
    logic [FREQ_W-1:0]  r_f_cur;
    logic [FREQ_W-1:0]  r_f_stop;
    logic [FREQ_W-1:0]  r_f_step;
    logic [FREQ_W-1:0]  r_tuning;
    logic [FREQ_W-1:0]  r_peak_freq;
    logic [MAG_W-1:0]   r_peak_mag;
    logic [3:0]         r_settle_cnt;
    logic               r_cfg_err;

    logic [FREQ_W:0]    w_next_f;
    logic               w_last_point;
    logic               w_cfg_bad;
    logic               w_start_ok;
    logic               w_settle_done;
    logic               w_avg_clear;
    logic               w_avg_strobe;
    logic [SUM_W-1:0]   w_avg_sum;
    logic               w_avg_done;
    logic [MAG_W-1:0]   w_avg_mag;
    logic               w_point_valid;
    logic               w_done;

    // The extra top bit catches a step that carries past the largest tuning word.
    assign w_next_f      = {1'b0, r_f_cur} + {1'b0, r_f_step};
    assign w_last_point  = w_next_f[FREQ_W] || (w_next_f > {1'b0, r_f_stop});
    assign w_cfg_bad     = (i_f_step == '0) || (i_f_start > i_f_stop);
    assign w_start_ok    = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_settle_done = (SETTLE_N == 0) ||
                           (i_result_valid && (r_settle_cnt == SETTLE_LAST));
    assign w_avg_clear   = (r_state == S_APPLY);
    assign w_avg_strobe  = (r_state == S_ACQUIRE) && i_result_valid;
    assign w_avg_mag     = w_avg_sum[AVG_LOG2 +: MAG_W];

    sweep_averager #(
        .MAG_W    (MAG_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_averager (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_avg_clear),
        .i_strobe (w_avg_strobe),
        .i_mag    (i_magnitude),
        .o_sum    (w_avg_sum),
        .o_done   (w_avg_done)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and pulse outputs; abort overrides every transition.
    always_comb begin
        w_next_state  = r_state;
        w_point_valid = (r_state == S_STORE) && !i_abort;
        w_done        = (r_state == S_DONE) && !i_abort;
        if (i_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (i_start) w_next_state = w_cfg_bad ? S_DONE : S_APPLY;
                S_APPLY:   w_next_state = S_SETTLE;
                S_SETTLE:  if (w_settle_done) w_next_state = S_ACQUIRE;
                S_ACQUIRE: if (w_avg_done) w_next_state = S_STORE;
                S_STORE:   w_next_state = w_last_point ? S_DONE : S_APPLY;
                S_DONE:    w_next_state = S_IDLE;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    // Sweep configuration, current frequency, tuning word and peak tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_f_cur     <= '0;
            r_f_stop    <= '0;
            r_f_step    <= '0;
            r_tuning    <= '0;
            r_peak_freq <= '0;
            r_peak_mag  <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_f_cur     <= i_f_start;
                r_f_stop    <= i_f_stop;
                r_f_step    <= i_f_step;
                r_peak_freq <= '0;
                r_peak_mag  <= '0;
                r_cfg_err   <= w_cfg_bad;
                if (!w_cfg_bad) begin
                    r_tuning <= i_f_start;
                end
            end
            if (w_point_valid) begin
                // Strictly greater: on a tie the earlier frequency stays the peak.
                if (w_avg_mag > r_peak_mag) begin
                    r_peak_mag  <= w_avg_mag;
                    r_peak_freq <= r_f_cur;
                end
                if (!w_last_point) begin
                    r_f_cur  <= w_next_f[FREQ_W-1:0];
                    r_tuning <= w_next_f[FREQ_W-1:0];
                end
            end
        end
    end

    // Count discarded settling strobes; restarted on every new point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_settle_cnt <= '0;
        end else if (r_state == S_APPLY) begin
            r_settle_cnt <= '0;
        end else if ((r_state == S_SETTLE) && i_result_valid) begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
        end
    end

    assign o_tuning_word = r_tuning;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = w_done;
    assign o_cfg_err     = r_cfg_err;
    assign o_point_valid = w_point_valid;
    assign o_point_freq  = w_point_valid ? r_f_cur : '0;
    assign o_point_mag   = w_point_valid ? w_avg_mag : '0;
    assign o_peak_freq   = r_peak_freq;
    assign o_peak_mag    = r_peak_mag;
    assign o_dbg_state   = r_state;

endmodule
